axis_pkt_sched: RTL
===================

# axis_pkt_sched

Packet-level round-robin scheduler that shares one `axis_fifo` instance between `NUM_SRC` AXI-Stream sources. It holds the grant for a source until that packet's last beat is written. It then asserts `RECE_DONE` to release the FIFO's store-and-forward read side, and blocks all sources until the FIFO has drained the same number of beats. It sits directly in front of `axis_fifo`: it drives the FIFO slave port and monitors the FIFO master-port handshake.

## Interface
- `DATA_WIDTH`, 16: beat width in bits; keep width is `DATA_WIDTH/8`.
- `NUM_SRC`, 4: number of requesting sources, 2..8.
- `MAX_PKT_BEATS`, 16384: beat limit per packet; must not exceed the FIFO depth (2^ADDR_DEPTH).
- `CNT_W`, 15: beat counter width; must satisfy 2^CNT_W > MAX_PKT_BEATS.
- `clk`  in  1: clock; all logic is on the rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `s_tdata`  in  NUM_SRC*DATA_WIDTH: source data, source i at slice [i*DATA_WIDTH +: DATA_WIDTH].
- `s_tkeep`  in  NUM_SRC*DATA_WIDTH/8: source keep, packed the same way.
- `s_tvalid`  in  NUM_SRC: per-source valid.
- `s_tlast`  in  NUM_SRC: per-source last.
- `s_tready`  out  NUM_SRC: per-source ready.
- `f_tdata`  out  DATA_WIDTH: to FIFO `s_tdata`.
- `f_tkeep`  out  DATA_WIDTH/8: to FIFO `s_tkeep`.
- `f_tvalid`  out  1: to FIFO `s_tvalid`.
- `f_tlast`  out  1: to FIFO `s_tlast`.
- `f_tready`  in  1: from FIFO `s_tready`.
- `o_tvalid`  in  1: monitor of FIFO `m_tvalid`.
- `o_tready`  in  1: monitor of FIFO `m_tready`.
- `rece_done`  out  1: to FIFO `RECE_DONE`; level signal.
- `grant_id`  out  $clog2(NUM_SRC): currently or last granted source.
- `busy`  out  1: high in any state other than IDLE.
- `trunc_err`  out  1: one-cycle pulse when a packet is force-terminated at the beat limit.

## Operation
- States:
  - IDLE: no grant; all `s_tready`=0; `f_tvalid`=0.
  - FILL: grant held; datapath is a combinational mux from the granted source to the FIFO.
  - DRAIN: `rece_done`=1; all `s_tready`=0; waits for the FIFO to empty.
- IDLE->FILL:
  - Triggered by any `s_tvalid` bit high.
  - Winner is the first requester at or after (`last_grant`+1) mod NUM_SRC, searching upward with wrap.
  - `last_grant` and `grant_id` update on the same edge.
  - `last_grant` resets to NUM_SRC-1, so source 0 wins first.
- FILL datapath, with g = grant:
  - `f_tdata/f_tkeep/f_tvalid` = source g's signals.
  - `s_tready[g]` = `f_tready`; all other `s_tready` = 0.
- Beat count:
  - `in_cnt` clears on entry to FILL.
  - It increments on each beat with `f_tvalid & f_tready`.
- `f_tlast` = `s_tlast[g]` | (`in_cnt` == MAX_PKT_BEATS-1).
- FILL->DRAIN: on an accepted beat with `f_tlast`=1.
  - If that beat's `s_tlast[g]` was 0, pulse `trunc_err` for one cycle.
  - The source's remaining beats are treated as a new packet in a later arbitration.
- DRAIN:
  - `out_cnt` clears on entry.
  - It increments on each beat with `o_tvalid & o_tready`.
  - When an output beat is accepted and `out_cnt`+1 == `in_cnt`, go to IDLE.
- Only one packet is resident in the FIFO at a time. Arbitration never overlaps DRAIN.
- Source valid dropping mid-packet in FILL: the grant is held, `f_tvalid`=0, and there is no timeout.
- Reset mid-operation: immediate return to IDLE, counters cleared, all outputs at their reset values. The FIFO shares `rst_n`.

## Timing
- Reset values:
  - `rece_done`=0, `busy`=0, `trunc_err`=0, `grant_id`=0.
  - `s_tready`=0, `f_tvalid`=0, `f_tlast`=0, `f_tdata`=0, `f_tkeep`=0.
- Grant latency: request seen in IDLE at edge N, state FILL after edge N, first beat can transfer in cycle N+1.
- `rece_done` is registered:
  - Rises the cycle after the last beat's handshake edge.
  - Falls the cycle after the final output beat's handshake edge (IDLE entry).
- `busy` = (state != IDLE), registered state decode.
- The earliest next grant is evaluated in the first IDLE cycle. This gives one idle cycle between DRAIN exit and the next FILL.
- Output handshakes in FILL are ignored by `out_cnt`. Input handshakes in DRAIN cannot occur.
- Counter widths:
  - `in_cnt` and `out_cnt` are CNT_W bits and never wrap, because the limit is MAX_PKT_BEATS.
  - Compare `out_cnt`+1 in CNT_W+1 bits.
- `f_*` outputs are combinational from the source inputs in FILL, and forced to 0 otherwise.

## Test plan
- Single source 0, 8-beat packet, tlast on beat 8, FIFO always ready, o_tready=1 once `rece_done` is high:
  - 8 beats written, `rece_done` high, 8 beats drained.
  - `rece_done` falls the cycle after the 8th output handshake; `busy` 0 after.
- Sources 0, 1 and 3 all valid with 4-beat packets:
  - Grant order is 0, 1, 3, 0.
  - No beat of source 1 appears until source 0's drain completes.
  - `s_tready` is 0 for non-granted sources throughout.
- Source 2 sends 20 beats with no tlast, MAX_PKT_BEATS=16:
  - `f_tlast` on beat 16, `trunc_err` pulses once.
  - After drain, the remaining 4 beats are re-granted as a second packet.
- Source 0 valid toggles every other cycle during FILL, with `f_tready` held low for 3 cycles mid-packet:
  - No beat lost or duplicated; data at the FIFO side is identical to the source.
  - `in_cnt`=6 for a 6-beat packet.
- Reset asserted in DRAIN after 3 of 10 output beats:
  - All outputs at reset values asynchronously.
  - The next request is granted to source 0.
- Requests on sources 0 and 1 on the same edge, and a new request arriving during DRAIN:
  - Lowest-index eligible source wins the first grant.
  - The DRAIN request waits and is granted in the first IDLE cycle.

Source files
------------

// File: rtl/axis_pkt_sched.sv
// Packet-level round-robin scheduler in front of a single store-and-forward axis_fifo.
// One packet is resident in the FIFO at a time; sources are blocked until it drains.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// ST_IDLE  | no grant, all sources blocked, round-robin arbitration on s_tvalid
// ST_FILL  | grant held, granted source muxed straight through to the FIFO
// ST_DRAIN | rece_done high, all sources blocked, wait for FIFO to empty
module axis_pkt_sched #(
    parameter int DATA_WIDTH    = 16,
    parameter int NUM_SRC       = 4,
    parameter int MAX_PKT_BEATS = 16384,
    parameter int CNT_W         = 15
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]    s_tdata,
    input  logic [NUM_SRC*DATA_WIDTH/8-1:0]  s_tkeep,
    input  logic [NUM_SRC-1:0]               s_tvalid,
    input  logic [NUM_SRC-1:0]               s_tlast,
    output logic [NUM_SRC-1:0]               s_tready,
    output logic [DATA_WIDTH-1:0]            f_tdata,
    output logic [DATA_WIDTH/8-1:0]          f_tkeep,
    output logic                             f_tvalid,
    output logic                             f_tlast,
    input  logic                             f_tready,
    input  logic                             o_tvalid,
    input  logic                             o_tready,
    output logic                             rece_done,
    output logic [$clog2(NUM_SRC)-1:0]       grant_id,
    output logic                             busy,
    output logic                             trunc_err
);

    localparam int KW = DATA_WIDTH / 8;
    localparam int GW = $clog2(NUM_SRC);
    localparam logic [CNT_W-1:0] LP_LIMIT = CNT_W'(MAX_PKT_BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [GW-1:0]    r_grant;
    logic [GW-1:0]    r_last_grant;
    logic [GW-1:0]    w_win;
    logic             w_found;
    logic             w_any_req;
    logic [CNT_W-1:0] r_in_cnt;
    logic [CNT_W-1:0] r_out_cnt;
    logic             r_rece_done;
    logic             r_trunc_err;
    logic             w_src_last;
    logic             w_at_limit;
    logic             w_beat_in;
    logic             w_beat_out;
    logic             w_last_out;

    assign w_any_req  = |s_tvalid;
    assign w_at_limit = (r_in_cnt == LP_LIMIT);
    assign w_beat_in  = (r_state == ST_FILL) & f_tvalid & f_tready;
    assign w_beat_out = (r_state == ST_DRAIN) & o_tvalid & o_tready;
    assign w_last_out = (({1'b0, r_out_cnt} + (CNT_W+1)'(1)) == {1'b0, r_in_cnt});

    // Search upward from last_grant+1 with wrap; the first requester found wins.
    always_comb begin
        w_win   = r_last_grant;
        w_found = 1'b0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            int v_sum;
            v_sum = int'(r_last_grant) + k;
            if (v_sum >= NUM_SRC) begin
                v_sum = v_sum - NUM_SRC;
            end
            if (!w_found && s_tvalid[GW'(v_sum)]) begin
                w_found = 1'b1;
                w_win   = GW'(v_sum);
            end
        end
    end

    always_comb begin
        f_tdata    = '0;
        f_tkeep    = '0;
        f_tvalid   = 1'b0;
        f_tlast    = 1'b0;
        s_tready   = '0;
        w_src_last = 1'b0;
        if (r_state == ST_FILL) begin
            f_tdata    = s_tdata[r_grant*DATA_WIDTH +: DATA_WIDTH];
            f_tkeep    = s_tkeep[r_grant*KW +: KW];
            f_tvalid   = s_tvalid[r_grant];
            w_src_last = s_tlast[r_grant];
            f_tlast    = w_src_last | w_at_limit;
            s_tready[r_grant] = f_tready;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_any_req)              w_state_nxt = ST_FILL;
            ST_FILL:  if (w_beat_in && f_tlast)   w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_beat_out && w_last_out) w_state_nxt = ST_IDLE;
            default:                              w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= GW'(NUM_SRC - 1);
            r_in_cnt     <= '0;
            r_out_cnt    <= '0;
            r_rece_done  <= 1'b0;
            r_trunc_err  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rece_done <= (w_state_nxt == ST_DRAIN);
            // A limit-forced last beat without the source's own tlast is a truncation.
            r_trunc_err <= w_beat_in & f_tlast & ~w_src_last;

            if ((r_state == ST_IDLE) && w_any_req) begin
                r_grant      <= w_win;
                r_last_grant <= w_win;
                r_in_cnt     <= '0;
            end else if (w_beat_in) begin
                r_in_cnt <= r_in_cnt + CNT_W'(1);
            end

            if ((r_state == ST_FILL) && (w_state_nxt == ST_DRAIN)) begin
                r_out_cnt <= '0;
            end else if (w_beat_out) begin
                r_out_cnt <= r_out_cnt + CNT_W'(1);
            end
        end
    end

    assign rece_done = r_rece_done;
    assign trunc_err = r_trunc_err;
    assign grant_id  = r_grant;
    assign busy      = (r_state != ST_IDLE);

endmodule
